// File: rtl/bit_sender_pkg.sv
// bit_sender_pkg: shared types and constants for the LSB-first serial link.
// Holds the FSM state enum, payload width default, line levels, index width.
package bit_sender_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IDX_W      = $clog2(DATA_W_DEF) + 1;

  localparam logic LINE_IDLE   = 1'b0;
  localparam logic START_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

endpackage

// File: rtl/bit_sender_counter.sv
// bit_sender_counter: bit index for the DATA phase of a frame.
// Ports: clk, rst (async high), i_clr, i_en; o_last = (index == DATA_W-1).
module bit_sender_counter
  import bit_sender_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int IW = $clog2(DATA_W) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  logic [IW-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_en) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/bit_sender.sv
// bit_sender: byte-in, single-wire frame out (start 1, 8 data LSB first, stop 0).
// Ports: clk, rst (async high), tx_valid, data_in -> tx_ready, serial_out,
// busy, tx_done. Define BIT_SENDER_PARITY_EN to add an even-parity bit.
module bit_sender
  import bit_sender_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              tx_done
);

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_shreg;
  logic              w_accept;
  logic              w_last;
  logic              w_cnt_clr;
  logic              w_cnt_en;

`ifdef BIT_SENDER_PARITY_EN
  logic r_par;
`endif

  assign w_accept = (r_state == S_IDLE) && tx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: w_next = S_DATA;
      S_DATA: begin
        w_cnt_en = 1'b1;
        if (w_last) begin
`ifdef BIT_SENDER_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
      S_PARITY: w_next = S_STOP;
      S_STOP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= data_in;
    end else if (r_state == S_DATA) begin
      r_shreg <= r_shreg >> 1;
    end
  end

`ifdef BIT_SENDER_PARITY_EN
  // Parity is taken from the byte as accepted, not the shifting copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^data_in;
    end
  end
`endif

  bit_sender_counter #(
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_last (w_last)
  );

  // Line decoded from state only, so reset drops it asynchronously.
  always_comb begin
    serial_out = LINE_IDLE;
    unique case (r_state)
      S_START: serial_out = START_LEVEL;
      S_DATA:  serial_out = r_shreg[0];
`ifdef BIT_SENDER_PARITY_EN
      S_PARITY: serial_out = r_par;
`else
      S_PARITY: serial_out = LINE_IDLE;
`endif
      default: serial_out = LINE_IDLE;
    endcase
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign tx_done  = (r_state == S_STOP);

endmodule

// File: tb/tb_bit_sender.sv
// tb_bit_sender: scoreboard bench for bit_sender.
// Accept model pushes expected line samples; negedge monitor pops and checks.
module tb_bit_sender;

`ifdef BIT_SENDER_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready;
  logic       serial_out;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int misses  = 0;
  int m_cnt   = 0;
  int acc_cnt = 0;

  // {serial_out, tx_done} per busy cycle
  logic [1:0] sb[$];

  bit_sender dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .data_in    (data_in),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      misses++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, got, want);
    end
  endtask

  // Accept model: idle when m_cnt==0, busy for FRAME cycles after accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      sb.delete();
    end else if (m_cnt == 0 && tx_valid) begin
      acc_cnt++;
      m_cnt = FRAME;
      sb.push_back(2'b10);
      for (int i = 0; i < 8; i++) sb.push_back({data_in[i], 1'b0});
`ifdef BIT_SENDER_PARITY_EN
      sb.push_back({^data_in, 1'b0});
`endif
      sb.push_back(2'b01);
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
  end

  always @(negedge clk) begin
    logic       eb;
    logic [1:0] e;
    eb = (m_cnt != 0);
    chk("busy", busy, eb);
    chk("tx_ready", tx_ready, !eb);
    if (busy === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        misses++;
        $display("FAIL sb_empty @%0t: got busy line with no frame pending", $time);
      end else begin
        e = sb.pop_front();
        chk("serial_out", serial_out, e[1]);
        chk("tx_done", tx_done, e[0]);
      end
    end else begin
      chk("idle_line", serial_out, 1'b0);
      chk("idle_done", tx_done, 1'b0);
    end
  end

  task automatic send(input logic [7:0] d);
    int n0;
    n0 = acc_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = d;
    for (int i = 0; i < 40 && acc_cnt == n0; i++) @(posedge clk);
    #1;
    vectors++;
    if (acc_cnt == n0) begin
      misses++;
      $display("FAIL accept_timeout: got no accept want accept of %h", d);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk("rst_line", serial_out, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int a0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset while idle
    #2 rst_pulse();
    repeat (2) @(negedge clk);

    // 0xA5 with a busy-time request for 0x3C that must be ignored
    send(8'hA5);
    a0 = acc_cnt;
    repeat (3) @(negedge clk);
    tx_valid = 1'b1;
    data_in  = 8'h3C;
    @(negedge clk);
    tx_valid = 1'b0;
    data_in  = 8'h00;
    repeat (10) @(negedge clk);
    vectors++;
    if (acc_cnt != a0) begin
      misses++;
      $display("FAIL busy_ignore: got %0d accepts want %0d", acc_cnt, a0);
    end

    // back-to-back 0xFF then 0x00 with tx_valid held
    a0 = acc_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk);
    #1;
    repeat (5) @(negedge clk);
    data_in = 8'h00;
    for (int i = 0; i < 40 && acc_cnt < a0 + 2; i++) @(posedge clk);
    #1;
    vectors++;
    if (acc_cnt != a0 + 2) begin
      misses++;
      $display("FAIL b2b_accepts: got %0d want %0d", acc_cnt - a0, 2);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (12) @(negedge clk);

    // reset mid-frame, then a clean 0x81
    send(8'h5A);
    repeat (3) @(negedge clk);
    #2 rst_pulse();
    repeat (2) @(negedge clk);
    send(8'h81);
    repeat (12) @(negedge clk);

`ifdef BIT_SENDER_PARITY_EN
    send(8'h01);
    repeat (12) @(negedge clk);
    send(8'hA5);
    repeat (12) @(negedge clk);
`endif

    vectors++;
    if (sb.size() != 0) begin
      misses++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/bit_sender.md
# bit_sender

Serial transmitter for the team's rise-triggered, LSB-first 8-bit serial link. It accepts a parallel byte through a valid/ready handshake and drives a single-wire frame: one high start cycle, 8 data cycles LSB first, then one low stop cycle. It sits on the transmit side, opposite the serial receiver, which detects the start rise and shifts 8 bits in. It can be started from the receiver's wake output to build an echo path.

## Interface
- DATA_W, 8, payload width in bits; the link protocol fixes it at 8.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  request to send `data_in`.
- data_in  input  DATA_W  byte to send; sampled only on accept.
- tx_ready  output  1  high only in IDLE.
- serial_out  output  1  serial line; idle level 0.
- busy  output  1  high from START through STOP inclusive.
- tx_done  output  1  one-cycle pulse during the STOP cycle.

## Operation
- States: IDLE, START, DATA, optional PARITY, STOP.
  - IDLE: `tx_ready`=1, `serial_out`=0.
  - Accept happens on an edge where `tx_valid && tx_ready`. On accept, `data_in` loads into the shift register, the bit index clears to 0, and the state goes to START.
  - START: `serial_out`=1 for exactly 1 cycle, then DATA.
  - DATA: `serial_out`=shreg[0]. The register shifts right each cycle and the index increments. After the cycle with index DATA_W-1, the state goes to PARITY (if compiled in) or STOP.
  - STOP: `serial_out`=0 and `tx_done`=1 for 1 cycle, then IDLE.
- All outputs are decoded from registered state and the shift register only, with no combinational path from inputs. `tx_ready`, `busy` and `tx_done` may be decoded from state.
- `tx_valid` asserted while busy is ignored. There is no queueing, and `data_in` changes while busy have no effect.
- Reset values: state IDLE, `serial_out`=0, `tx_ready`=1, `busy`=0, `tx_done`=0, shift register 0, index 0.
- Reset mid-frame: `serial_out` drops to 0 immediately (asynchronously) and the frame is aborted. There is no `tx_done` for the aborted frame. The receiver sees a truncated frame; this is acceptable.
- The stop cycle plus the mandatory IDLE cycle give at least 2 low cycles between frames. A rise is therefore always present for the receiver, even when bit 7 is 1.

## Timing
- Accept at edge k. `serial_out` is then:
  - cycle k+1: start bit (1).
  - cycles k+2..k+9: bits d[0]..d[7].
  - cycle k+10: stop (0), with `tx_done`=1.
  - cycle k+11: IDLE, with `tx_ready`=1.
- Frame length is 10 cycles (11 with parity). Minimum accept-to-accept spacing is 11 cycles (12 with parity).
- `busy` is high on cycles k+1..k+10. `tx_ready` is low on the same cycles.
- Bit index width is clog2(DATA_W)+1. Its terminal test is `index == DATA_W-1`, with no wrap-around use.

## Configuration
- `BIT_SENDER_PARITY_EN` defined:
  - PARITY state inserted after DATA, one cycle.
  - `serial_out` = even parity = XOR of the accepted byte, captured at accept.
  - All later timings shift by +1 cycle.
- Undefined: no PARITY state; the frame is exactly as above, bit-compatible with the existing receiver.

## Structure
- Package `bit_sender_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the DATA_W default;
  - LINE_IDLE=0 and START_LEVEL=1;
  - the index width constant.
- Sub-module `bit_sender_counter` holds:
  - the bit index, with clear, enable and async reset;
  - the terminal flag `last` = (index == DATA_W-1).
- The top holds the FSM, the shift register and the output decode.

## Test plan
- Reset: assert `rst` mid-idle and check `serial_out`=0, `tx_ready`=1, `busy`=0, `tx_done`=0.
- Send 0xA5:
  - `serial_out` over cycles k+1..k+10 = 1,1,0,1,0,0,1,0,1,0.
  - `tx_done` high at k+10 only.
  - `tx_ready` high again at k+11.
- Back-to-back: hold `tx_valid`=1 with 0xFF then 0x00.
  - Second accept occurs exactly 11 cycles after the first.
  - Line is low for at least 2 cycles between the frames.
- Busy ignore: pulse `tx_valid` with 0x3C at k+4 during the 0xA5 frame. The frame is unchanged and there is no extra accept.
- Reset mid-frame: assert `rst` at k+5. `serial_out` goes 0 asynchronously, there is no `tx_done`, and a new 0x81 frame sent after release is correct.
- With `BIT_SENDER_PARITY_EN`:
  - 0x01 gives parity bit 1 at k+10, then stop at k+11.
  - 0xA5 gives parity bit 0.
  - Loopback into the receiver without parity: the received byte equals the sent byte for 0x00, 0x5A, 0xFF.
